// File: rtl/nibble_serial_addsub_if.sv
// Operand/control and result bundle for the nibble-serial add/sub unit.
// The master supplies operands; the slave (the unit) returns the result and flags.
interface nibble_serial_addsub_if #(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = 4 * NIBBLES;

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit add/sub: one nibble per clock, LSB nibble first, with the
// inter-nibble carry held in a register and registered result/flags.
module nibble_addsub_unit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       inv,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       co,
  output logic       c3
);
  logic [3:0] bx;
  logic [4:0] s;

  assign bx  = b ^ {4{inv}};
  assign s   = {1'b0, a} + {1'b0, bx} + {4'b0, cin};
  assign sum = s[3:0];
  assign co  = s[4];
  // carry into bit 3 recovered from the sum bit; needed for signed overflow
  assign c3  = a[3] ^ bx[3] ^ s[3];
endmodule

module nibble_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_addsub_if.slave bus
);
  localparam int WIDTH = 4 * NIBBLES;
  localparam int CW    = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-5:0] part_q;
  logic             sub_q, carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q, ovf_q, zero_q;

  logic             accept, last;
  logic [3:0]       sum;
  logic             co, c3;
  logic [WIDTH-1:0] part_nxt;

  nibble_addsub_unit u_nib (
    .a   (a_q[3:0]),
    .b   (b_q[3:0]),
    .inv (sub_q),
    .cin (carry_q),
    .sum (sum),
    .co  (co),
    .c3  (c3)
  );

  assign accept   = (state_q != RUN) && bus.start;
  assign last     = (state_q == RUN) && (cnt_q == LAST);
  // operands shift right, results shift in from the top: after NIBBLES steps
  // the full result is in order without any variable indexing
  assign part_nxt = {sum, part_q, 4'b0} >> 4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = bus.start ? RUN : IDLE;
      RUN:        if (cnt_q == LAST) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      sub_q   <= bus.sub;
      carry_q <= bus.sub;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 4;
      b_q     <= b_q >> 4;
      part_q  <= part_nxt[WIDTH-1:4];
      carry_q <= co;
      cnt_q   <= cnt_q + CW'(1);
      if (last) begin
        result_q <= part_nxt;
        cout_q   <= co;
        ovf_q    <= c3 ^ co;
        zero_q   <= (part_nxt == '0);
      end
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scenario bench for nibble_serial_addsub: expected results are queued at launch
// and popped when done is observed.
module tb_nibble_serial_addsub;
  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_addsub_if #(.NIBBLES(N)) bus ();
  nibble_serial_addsub #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   done_cnt = 0;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] full;
    full  = s ? ({1'b0, x} - {1'b0, y} + (1 << W)) : ({1'b0, x} + {1'b0, y});
    e.res = full[W-1:0];
    e.c   = full[W];
    e.v   = s ? ((x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]))
              : ((x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]));
    e.z   = (e.res == '0);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.sub   = s;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    q.push_back(model(s, x, y));
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  function automatic exp_t observed();
    exp_t o;
    o = {bus.result, bus.cout, bus.ovf, bus.zero};
    return o;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) step();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      fails++; $display("FAIL reset_ctrl got busy/done=%b want 00", {bus.busy, bus.done});
    end
    checks++;
    if (observed() !== '0) begin
      fails++; $display("FAIL reset_out got %h want 0", observed());
    end
    rst = 1'b0;
    step();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      fails++; $display("FAIL idle_ctrl got busy/done=%b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_add();
    int   lat, busy_cyc;
    exp_t e;
    launch(1'b0, 16'h1234, 16'h0F0F);
    lat = 0; busy_cyc = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busy_cyc++;
      step();
      lat++;
    end
    checks++;
    if (lat !== N) begin fails++; $display("FAIL add_latency got %0d want %0d", lat, N); end
    checks++;
    if (busy_cyc !== N) begin fails++; $display("FAIL add_busy_cycles got %0d want %0d", busy_cyc, N); end
    e = q.pop_front();
    checks++;
    if (observed() !== e) begin fails++; $display("FAIL add_result got %h want %h", observed(), e); end
    checks++;
    if (bus.result !== 16'h2143) begin fails++; $display("FAIL add_const got %h want 2143", bus.result); end
    checks++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL add_busy_at_done got %b want 0", bus.busy); end
    step();
    checks++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_sub();
    int   lat;
    exp_t e;
    launch(1'b1, 16'h0005, 16'h0007);
    wait_done(lat);
    e = q.pop_front();
    checks++;
    if (observed() !== e || lat !== N) begin
      fails++; $display("FAIL sub_borrow got %h lat %0d want %h lat %0d", observed(), lat, e, N);
    end
    checks++;
    if ({bus.result, bus.cout, bus.ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
      fails++; $display("FAIL sub_borrow_const got %h want fffe/0/0", {bus.result, bus.cout, bus.ovf});
    end
    step();
    launch(1'b1, 16'h8000, 16'h0001);
    wait_done(lat);
    e = q.pop_front();
    checks++;
    if (observed() !== e || lat !== N) begin
      fails++; $display("FAIL sub_ovf got %h lat %0d want %h lat %0d", observed(), lat, e, N);
    end
    checks++;
    if ({bus.result, bus.cout, bus.ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
      fails++; $display("FAIL sub_ovf_const got %h want 7fff/1/1", {bus.result, bus.cout, bus.ovf});
    end
    step();
  endtask

  task automatic test_ovf_wrap();
    int   lat;
    exp_t e;
    launch(1'b0, 16'h7FFF, 16'h0001);
    wait_done(lat);
    e = q.pop_front();
    checks++;
    if (observed() !== e || lat !== N) begin
      fails++; $display("FAIL add_ovf got %h lat %0d want %h lat %0d", observed(), lat, e, N);
    end
    checks++;
    if ({bus.result, bus.cout, bus.ovf, bus.zero} !== {16'h8000, 3'b010}) begin
      fails++; $display("FAIL add_ovf_const got %h want 8000/0/1/0", observed());
    end
    step();
    launch(1'b0, 16'hFFFF, 16'h0001);
    wait_done(lat);
    e = q.pop_front();
    checks++;
    if (observed() !== e || lat !== N) begin
      fails++; $display("FAIL wrap got %h lat %0d want %h lat %0d", observed(), lat, e, N);
    end
    checks++;
    if ({bus.result, bus.cout, bus.ovf, bus.zero} !== {16'h0000, 3'b101}) begin
      fails++; $display("FAIL wrap_const got %h want 0000/1/0/1", observed());
    end
    step();
  endtask

  task automatic test_busy_hold();
    int   lat, d0;
    logic held;
    exp_t e;
    d0 = done_cnt;
    launch(1'b0, 16'h0001, 16'h0001);
    step();
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.sub = 1'b1;
    wait_done(lat);
    e = q.pop_front();
    checks++;
    if (observed() !== e || lat !== N - 2) begin
      fails++; $display("FAIL busy_ignore got %h lat %0d want %h lat %0d", observed(), lat, e, N - 2);
    end
    held = 1'b1;
    repeat (8) begin
      step();
      if (bus.result !== 16'h0002 || bus.busy !== 1'b0) held = 1'b0;
    end
    checks++;
    if (!held) begin fails++; $display("FAIL idle_hold got %h want 0002 idle", bus.result); end
    checks++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL single_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic held;
    exp_t e;
    launch(1'b0, 16'h0001, 16'h0001);
    wait_done(lat);
    e = q.pop_front();
    checks++;
    if (observed() !== e) begin fails++; $display("FAIL b2b_first got %h want %h", observed(), e); end
    launch(1'b1, 16'h0010, 16'h0001);
    lat = 0; held = 1'b1;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.result !== 16'h0002) held = 1'b0;
      step();
      lat++;
    end
    checks++;
    if (!held) begin fails++; $display("FAIL b2b_hold got changed result want 0002"); end
    checks++;
    if (lat !== N) begin fails++; $display("FAIL b2b_latency got %0d want %0d", lat, N); end
    e = q.pop_front();
    checks++;
    if (observed() !== e || {bus.result, bus.cout} !== {16'h000F, 1'b1}) begin
      fails++; $display("FAIL b2b_second got %h want %h", observed(), e);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int   lat, d0;
    exp_t e;
    launch(1'b0, 16'h1111, 16'h2222);
    q.delete();
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00 || observed() !== '0) begin
      fails++; $display("FAIL reset_mid got busy/done=%b out=%h want 00/0", {bus.busy, bus.done}, observed());
    end
    d0 = done_cnt;
    step();
    rst = 1'b0;
    repeat (10) step();
    checks++;
    if (done_cnt !== d0) begin fails++; $display("FAIL reset_no_done got %0d dones want 0", done_cnt - d0); end
    launch(1'b1, 16'h1234, 16'h1234);
    wait_done(lat);
    e = q.pop_front();
    checks++;
    if (observed() !== e || lat !== N) begin
      fails++; $display("FAIL after_reset got %h lat %0d want %h lat %0d", observed(), lat, e, N);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ovf_wrap();
    test_busy_hold();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
